// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration on ties (default: data has fixed priority).
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state;
  logic              owner_data;
  logic [DATA_W-1:0] resp_q;
  logic              grant_data;
  logic              accept;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_data;

  // On a tie the side that did not win last time goes first.
  always_comb grant_data = data_req && (!inst_req || !last_grant_data);
`else
  always_comb grant_data = data_req;
`endif

  always_comb accept = (state == IDLE) && (inst_req || data_req);

  assign inst_addr_ok = accept && !grant_data;
  assign data_addr_ok = accept && grant_data;
  assign inst_rdata   = resp_q;
  assign data_rdata   = resp_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      owner_data   <= 1'b0;
      resp_q       <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_size     <= 2'd0;
      mem_wstrb    <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_data <= 1'b0;
`endif
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner_data <= grant_data;
            mem_req    <= 1'b1;
            state      <= ADDR;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_data <= grant_data;
`endif
            if (grant_data) begin
              mem_wr    <= data_wr;
              mem_size  <= data_size;
              mem_wstrb <= data_wstrb;
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
            end else begin
              // Fetches are always full-word reads.
              mem_wr    <= 1'b0;
              mem_size  <= 2'd2;
              mem_wstrb <= '0;
              mem_addr  <= inst_addr;
              mem_wdata <= '0;
            end
          end
        end
        ADDR: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            resp_q       <= mem_rdata;
            inst_data_ok <= !owner_data;
            data_data_ok <= owner_data;
            state        <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: vector table, corner sequences and random traffic
// checked against a transaction-level model with a behavioural memory slave.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aw;
    int          dw;
    int          lat;
    logic [6:0]  ctl;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_pass = 0;

  // Requester side: pending flags and fields, applied to the ports each cycle.
  bit          inst_pend = 0, data_pend = 0;
  logic [31:0] p_inst_addr = '0;
  bit          p_wr = 0;
  logic [1:0]  p_size = '0;
  logic [3:0]  p_wstrb = '0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  // Transaction-level model of the arbiter.
  bit          busy = 0, owner_m = 0, hs_done = 1;
  int          cyc = 0, accept_cyc = 0, dok_cyc = -1;
  bit          e_wr = 0;
  logic [1:0]  e_size = '0;
  logic [3:0]  e_wstrb = '0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [31:0] last_resp = '0;
  int          last_lat = 0;
  bit          last_side = 0;
  int          done_side[$];
`ifdef ARB_ROUND_ROBIN_EN
  bit          last_data_m = 0;
`endif

  // Memory slave model.
  int          addr_wait = 0, data_wait = 0, a_cnt = 0, d_cnt = 0;
  bit          pend_d = 0, rand_mode = 0, stray_en = 0, force_stray = 0;
  logic [31:0] resp_val = '0;
  logic [31:0] store [logic [31:0]];
  logic [6:0]  hs_ctl = '0;
  logic [31:0] hs_addr = '0, hs_wdata = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit pick_data(input bit i, input bit d);
`ifdef ARB_ROUND_ROBIN_EN
    if (i && d) return !last_data_m;
    return d;
`else
    return d;
`endif
  endfunction

  task automatic run_cycle();
    bit exp_mreq, exp_iaok, exp_daok, win, done_now;
    @(posedge clk);
    #1;
    cyc++;
    inst_req   = inst_pend;
    inst_addr  = p_inst_addr;
    data_req   = data_pend;
    data_wr    = p_wr;
    data_size  = p_size;
    data_wstrb = p_wstrb;
    data_addr  = p_addr;
    data_wdata = p_wdata;
    exp_mreq = busy && !hs_done && (cyc > accept_cyc);
    check_output("mem_req", 32'(mem_req), 32'(exp_mreq));
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (pend_d) begin
      if (d_cnt == data_wait) begin
        mem_data_ok = 1'b1;
        mem_rdata   = resp_val;
        pend_d      = 0;
        if (busy) dok_cyc = cyc + 1;
      end else d_cnt++;
    end else if (force_stray || (stray_en && $urandom_range(0, 3) == 0)) begin
      mem_data_ok = 1'b1;
      mem_rdata   = $urandom;
    end
    if (mem_req) begin
      check_output("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), 32'({e_wr, e_size, e_wstrb}));
      check_output("mem_addr", mem_addr, e_addr);
      check_output("mem_wdata", mem_wdata, e_wdata);
      if (a_cnt == addr_wait) begin
        mem_addr_ok = 1'b1;
        a_cnt    = 0;
        pend_d   = 1;
        d_cnt    = 0;
        hs_done  = 1;
        hs_ctl   = {mem_wr, mem_size, mem_wstrb};
        hs_addr  = mem_addr;
        hs_wdata = mem_wdata;
        resp_val = store.exists(e_addr) ? store[e_addr] : (e_addr ^ 32'hA5A5_5A5A);
        if (e_wr) store[e_addr] = e_wdata;
      end else a_cnt++;
    end else if (force_stray || (stray_en && $urandom_range(0, 3) == 0)) begin
      mem_addr_ok = 1'b1;
    end

    @(negedge clk);
    exp_iaok = 0;
    exp_daok = 0;
    win = 0;
    if (!busy && (inst_req || data_req)) begin
      win = pick_data(inst_req, data_req);
      exp_daok = win;
      exp_iaok = !win;
    end
    check_output("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_iaok));
    check_output("data_addr_ok", 32'(data_addr_ok), 32'(exp_daok));
    done_now = busy && (cyc == dok_cyc);
    check_output("inst_data_ok", 32'(inst_data_ok), 32'(done_now && !owner_m));
    check_output("data_data_ok", 32'(data_data_ok), 32'(done_now && owner_m));
    if (done_now) begin
      last_lat = cyc - accept_cyc;
      check_output("latency", 32'(last_lat), 32'(3 + addr_wait + data_wait));
      if (!e_wr) check_output("rdata", owner_m ? data_rdata : inst_rdata, resp_val);
      last_resp = resp_val;
      last_side = owner_m;
      done_side.push_back(int'(owner_m));
      busy = 0;
    end
    if (exp_iaok || exp_daok) begin
      busy = 1;
      owner_m = win;
      accept_cyc = cyc;
      hs_done = 0;
      dok_cyc = -1;
      if (win) begin
        e_wr = p_wr; e_size = p_size; e_wstrb = p_wstrb; e_addr = p_addr; e_wdata = p_wdata;
        data_pend = 0;
      end else begin
        e_wr = 0; e_size = 2'd2; e_wstrb = 4'h0; e_addr = p_inst_addr; e_wdata = '0;
        inst_pend = 0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      last_data_m = win;
`endif
      if (rand_mode) begin
        addr_wait = $urandom_range(0, 2);
        data_wait = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((busy || inst_pend || data_pend || pend_d) && n < budget) begin
      run_cycle();
      n++;
    end
    if (busy || inst_pend || data_pend || pend_d) check_output("idle_timeout", 32'(n), 32'(budget + 1));
  endtask

  // Asserts reset mid-cycle and expects every output to clear without waiting for a clock.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    inst_pend = 0; data_pend = 0;
    inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    resetn = 1'b0;
    #1;
    check_output("rst_mem_req", 32'(mem_req), 32'(0));
    check_output("rst_mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), 32'(0));
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_mem_wdata", mem_wdata, 32'h0);
    check_output("rst_ok", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'(0));
    check_output("rst_inst_rdata", inst_rdata, 32'h0);
    check_output("rst_data_rdata", data_rdata, 32'h0);
    busy = 0; hs_done = 1; a_cnt = 0; dok_cyc = -1; last_resp = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_m = 0;
`endif
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    addr_wait = v.aw;
    data_wait = v.dw;
    if (!v.wr) store[v.addr] = v.rdata;
    if (v.is_data) begin
      data_pend = 1; p_wr = v.wr; p_size = v.size; p_wstrb = v.wstrb; p_addr = v.addr; p_wdata = v.wdata;
    end else begin
      inst_pend = 1; p_inst_addr = v.addr;
    end
  endtask

  initial begin
    int n0, base;
    int exp_order[3];
    vecs[0] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'hBFC0_0000, 32'h0,         32'h3C08_0001, 0, 0, 3,  7'h20};
    vecs[1] = '{1'b1, 1'b1, 2'd2, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0,         0, 0, 3,  7'h6F};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h8000_1003, 32'h0,         32'h0000_00AB, 0, 0, 3,  7'h00};
    vecs[3] = '{1'b1, 1'b0, 2'd2, 4'h0, 32'h8000_2000, 32'h0,         32'h1234_5678, 3, 4, 10, 7'h20};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h8000_0040, 32'h0,         32'h2402_0007, 1, 0, 4,  7'h20};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 4'h3, 32'h8000_1006, 32'h0000_CAFE, 32'h0,         0, 2, 5,  7'h53};

    apply_reset();

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
      n0 = done_side.size();
      run_until_idle(40);
      check_output($sformatf("vec%0d_count", i), 32'(done_side.size() - n0), 32'(1));
      check_output($sformatf("vec%0d_side", i), 32'(last_side), 32'(vecs[i].is_data));
      check_output($sformatf("vec%0d_latency", i), 32'(last_lat), 32'(vecs[i].lat));
      check_output($sformatf("vec%0d_ctl", i), 32'(hs_ctl), 32'(vecs[i].ctl));
      check_output($sformatf("vec%0d_addr", i), hs_addr, vecs[i].addr);
      check_output($sformatf("vec%0d_wdata", i), hs_wdata, vecs[i].is_data ? vecs[i].wdata : 32'h0);
      if (!vecs[i].wr)
        check_output($sformatf("vec%0d_rdata", i), vecs[i].is_data ? data_rdata : inst_rdata, vecs[i].rdata);
    end

    // Stray handshakes while idle must not disturb anything.
    force_stray = 1;
    run_cycle();
    run_cycle();
    force_stray = 0;
    check_output("stray_inst_rdata", inst_rdata, last_resp);
    check_output("stray_data_rdata", data_rdata, last_resp);
    addr_wait = 0; data_wait = 0;
    inst_pend = 1; p_inst_addr = 32'hBFC0_0004;
    run_until_idle(40);
    check_output("post_stray_latency", 32'(last_lat), 32'(3));

    // Reset while waiting for read data: the late response must be dropped.
    addr_wait = 0; data_wait = 5;
    data_pend = 1; p_wr = 0; p_size = 2'd2; p_wstrb = 4'h0; p_addr = 32'h8000_3000;
    for (int n = 0; n < 20 && !(busy && hs_done); n++) run_cycle();
    run_cycle();
    check_output("in_data_before_reset", 32'(busy && hs_done), 32'(1));
    n0 = done_side.size();
    apply_reset();
    repeat (8) run_cycle();
    check_output("no_dok_after_reset", 32'(done_side.size() - n0), 32'(0));
    data_wait = 0;
    inst_pend = 1; p_inst_addr = 32'hBFC0_0100;
    run_until_idle(40);
    check_output("after_reset_side", 32'(done_side.size() - n0), 32'(1));

    // Both sides requesting continuously across three grants.
    apply_reset();
    addr_wait = 0; data_wait = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1};
`else
    exp_order = '{1, 1, 1};
`endif
    base = done_side.size();
    for (int n = 0; n < 60 && done_side.size() < base + 3; n++) begin
      if (!inst_pend) begin inst_pend = 1; p_inst_addr = 32'hBFC0_0200 + 32'(n * 4); end
      if (!data_pend) begin
        data_pend = 1; p_wr = 0; p_size = 2'd2; p_wstrb = 4'h0; p_addr = 32'h8000_4000 + 32'(n * 4);
      end
      run_cycle();
    end
    run_until_idle(60);
    for (int k = 0; k < 3; k++)
      check_output($sformatf("tie_order%0d", k),
                   (done_side.size() > base + k) ? 32'(done_side[base + k]) : 32'hFFFF_FFFF,
                   32'(exp_order[k]));

    // Random traffic with random memory stalls and stray handshakes.
    rand_mode = 1; stray_en = 1;
    for (int n = 0; n < 500; n++) begin
      if (!inst_pend && $urandom_range(0, 2) == 0) begin
        inst_pend = 1; p_inst_addr = {$urandom_range(0, 255), 2'b00};
      end
      if (!data_pend && $urandom_range(0, 2) == 0) begin
        data_pend = 1;
        p_wr      = 1'($urandom_range(0, 1));
        p_size    = 2'($urandom_range(0, 2));
        p_wstrb   = 4'($urandom);
        p_addr    = {$urandom_range(0, 255), 2'b00};
        p_wdata   = $urandom;
      end
      run_cycle();
    end
    run_until_idle(200);
    stray_en = 0; rand_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares a single SRAM-like memory port between the core's instruction-fetch side and data-access side. It sits between the CPU core's inst/data request interfaces and the unified bus port. It accepts one transaction at a time, registers it, drives it downstream with a req/addr_ok/data_ok handshake, and returns read data to the granted requester. It is the first step toward replacing the dual fixed SRAM ports with a single AXI-bridged port.

## Interface
- ADDR_W, 32, address width for requesters and memory port
- DATA_W, 32, data width; byte strobes are DATA_W/8 bits

- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request (read-only), held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  one-cycle pulse: fetch request accepted
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request, held until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 byte, 1 half, 2 word
- data_wstrb  in  DATA_W/8  byte enables (writes)
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  one-cycle pulse: data request accepted
- data_data_ok  out  1  one-cycle pulse: read data valid / write complete
- data_rdata  out  DATA_W  read data
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  downstream request fields, all registered
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data

## Operation
- States: IDLE, ADDR, DATA, RESP. Reset state IDLE.
- IDLE: if any req, pick grant (see Configuration), pulse that requester's addr_ok combinationally this cycle, latch its fields into mem_* registers and owner flag (inst requests latch wr=0, size=2, wstrb=0, wdata=0) -> ADDR. No req: stay.
- ADDR: mem_req=1, fields stable. On mem_addr_ok: mem_req falls next cycle -> DATA.
- DATA: wait mem_data_ok; on it capture mem_rdata into response register -> RESP.
- RESP: owner's data_ok=1 for exactly this cycle with rdata from the register -> IDLE. Non-owner data_ok stays 0; for writes rdata is don't-care but the register is still loaded.
- Only one transaction outstanding; a requester not granted keeps req high and is served in a later IDLE.
- mem_data_ok in IDLE, ADDR or RESP is ignored. mem_addr_ok outside ADDR is ignored.
- Reset mid-transaction: return to IDLE, in-flight transaction dropped, no data_ok issued.

## Timing
- Reset values: mem_req 0, all mem_* fields 0, both addr_ok 0, both data_ok 0, both rdata 0, owner = inst.
- addr_ok is combinational from state and req (same cycle as accept); all other outputs registered.
- Zero-wait memory (mem_addr_ok high while mem_req, mem_data_ok the cycle after): accept cycle N, mem_req cycle N+1, mem_data_ok N+2, requester data_ok N+3, next accept earliest N+4.
- Each additional mem_addr_ok or mem_data_ok wait cycle adds one cycle of latency.

## Configuration
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data wins every simultaneous request; sustained data traffic may starve fetch.
- ARB_ROUND_ROBIN_EN defined: a last_grant register (reset = inst) is added; on simultaneous requests grant the side not granted last; single requests granted directly and update last_grant. First tie after reset therefore goes to data in both builds.

## Test plan
- Single fetch: inst_req=1, inst_addr=0xBFC00000, zero-wait memory returning 0x3C080001 -> inst_addr_ok pulse cycle N, mem_addr=0xBFC00000 mem_wr=0 cycle N+1, inst_data_ok with inst_rdata=0x3C080001 at N+3, data side silent.
- Data write: data_wr=1, size=2, wstrb=0xF, addr=0x80001000, wdata=0xDEADBEEF -> mem_* carry exactly these values while mem_req, data_data_ok one pulse, inst_data_ok never.
- Simultaneous: inst_req and data_req held high for three transactions -> fixed build: data, data, data; round-robin build: data, inst, data.
- Stall: mem_addr_ok low 3 cycles, mem_data_ok 4 cycles late -> mem_req held with stable fields for 4 cycles, data_ok arrives 7 cycles later than zero-wait case.
- Reset in DATA: resetn low during wait -> all outputs 0 asynchronously, a subsequent mem_data_ok produces no data_ok, next request served normally.
- Stray response: mem_data_ok=1 while IDLE -> no data_ok on either side, state unchanged.
